sha3_digest_serializer: RTL and testbench

Drains finished Keccak-f[1600] states from the last `sha3_round_function` stage (ROUND_INDEX 23) and emits the digest as a valid/ready word stream. It is the consumer end of the round pipeline's five-row `sample`/`ogood` interface, which has no backpressure. One holding slot decouples the free-running pipeline from a stalling downstream sink. Overflow is flagged, never silent.

---
 rtl/sha3_digest_serializer_if.sv | 12 +
 rtl/sha3_digest_serializer.sv | 139 +++++++++++++
 tb/tb_sha3_digest_serializer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_digest_serializer_if.sv
// Digest word stream: valid/ready handshake with an end-of-digest marker.
interface sha3_digest_serializer_if #(
  parameter int unsigned OUT_WIDTH = 32
);
  logic [OUT_WIDTH-1:0] odata;
  logic                 ovalid;
  logic                 olast;
  logic                 iready;

  modport master (output odata, output ovalid, output olast, input iready);
  modport slave  (input odata, input ovalid, input olast, output iready);
endinterface

// File: rtl/sha3_digest_serializer.sv
// Captures finished Keccak states from the last round stage and streams the digest
// as OUT_WIDTH-bit words. One holding slot absorbs a result that arrives while the
// previous digest is still streaming; a further result is dropped and flagged.
module sha3_digest_serializer #(
  parameter int unsigned DIGEST_BITS = 256,
  parameter int unsigned OUT_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [63:0]                     isa [0:4],
  input  logic [63:0]                     isb [0:4],
  input  logic [63:0]                     isc [0:4],
  input  logic [63:0]                     isd [0:4],
  input  logic [63:0]                     ise [0:4],
  input  logic                            sample,
  sha3_digest_serializer_if.master        dout,
  output logic                            ofree,
  output logic                            overflow
);

  localparam int unsigned NumWords = (DIGEST_BITS + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);
  // Keeps digest bits only; lanes beyond the digest and the tail of a partial lane read 0.
  localparam logic [511:0] KeepMask = {512{1'b1}} >> (512 - DIGEST_BITS);

  if (!(DIGEST_BITS == 224 || DIGEST_BITS == 256 || DIGEST_BITS == 384 ||
        DIGEST_BITS == 512)) begin : g_bad_digest
    $error("sha3_digest_serializer: DIGEST_BITS must be 224, 256, 384 or 512");
  end
  if (!(OUT_WIDTH == 32 || OUT_WIDTH == 64)) begin : g_bad_width
    $error("sha3_digest_serializer: OUT_WIDTH must be 32 or 64");
  end

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e          r_state, w_state_next;
  logic [IdxW-1:0] r_idx, w_idx_next;
  logic [511:0]    r_act, w_act_next;
  logic [511:0]    r_hold, w_hold_next;
  logic            r_hold_full, w_hold_full_next;
  logic            r_overflow, w_overflow_next;

  logic [511:0]          w_in;
  logic [OUT_WIDTH-1:0]  w_word;
  logic                  w_valid;
  logic                  w_beat;
  logic                  w_finish;
  logic                  w_unused;

  // Lanes 0..7 are the top row plus the first three lanes of the second row.
  assign w_in = {isb[2], isb[1], isb[0], isa[4], isa[3], isa[2], isa[1], isa[0]} & KeepMask;

  // Rows and lanes that can never hold digest bits.
  assign w_unused = ^{isb[3], isb[4], isc[0], isc[1], isc[2], isc[3], isc[4],
                      isd[0], isd[1], isd[2], isd[3], isd[4],
                      ise[0], ise[1], ise[2], ise[3], ise[4]};

  assign w_valid  = (r_state == StStream);
  assign w_beat   = w_valid & dout.iready;
  assign w_finish = w_beat & (r_idx == LastIdx);

  // Select the current word out of the active buffer.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < int'(NumWords); k++) begin
      if (r_idx == IdxW'(k)) w_word = r_act[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign dout.ovalid = w_valid;
  assign dout.olast  = w_valid & (r_idx == LastIdx);
  assign dout.odata  = w_valid ? w_word : '0;
  assign ofree       = ~r_hold_full;
  assign overflow    = r_overflow;

  // Next-state: word counter, buffer moves and overflow detection.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_act_next       = r_act;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_overflow_next  = r_overflow;
    unique case (r_state)
      StIdle: begin
        if (sample) begin
          w_act_next   = w_in;
          w_idx_next   = '0;
          w_state_next = StStream;
        end
      end
      StStream: begin
        if (w_beat) w_idx_next = r_idx + 1'b1;
        if (w_finish) begin
          w_idx_next = '0;
          if (r_hold_full) begin
            // Holding slot drains into active; a coincident sample refills it.
            w_act_next = r_hold;
            if (sample) w_hold_next = w_in;
            else        w_hold_full_next = 1'b0;
          end else if (sample) begin
            w_act_next = w_in;
          end else begin
            w_state_next = StIdle;
          end
        end else if (sample) begin
          if (!r_hold_full) begin
            w_hold_next      = w_in;
            w_hold_full_next = 1'b1;
          end else begin
            w_overflow_next = 1'b1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_act       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_act       <= w_act_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
      r_overflow  <= w_overflow_next;
    end
  end

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Directed bench for three digest/width configurations sharing one stimulus bus.
module tb_sha3_digest_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        iready = 1'b0;
  logic [63:0] isa [0:4];
  logic [63:0] isb [0:4];
  logic [63:0] isc [0:4];
  logic [63:0] isd [0:4];
  logic [63:0] ise [0:4];
  logic        ofree0, ofree1, ofree2;
  logic        ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  sha3_digest_serializer_if #(.OUT_WIDTH(32)) if0 ();
  sha3_digest_serializer_if #(.OUT_WIDTH(64)) if1 ();
  sha3_digest_serializer_if #(.OUT_WIDTH(32)) if2 ();
  assign if0.iready = iready;
  assign if1.iready = iready;
  assign if2.iready = iready;

  sha3_digest_serializer #(.DIGEST_BITS(256), .OUT_WIDTH(32)) u_d256 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(sample), .dout(if0), .ofree(ofree0), .overflow(ovf0));
  sha3_digest_serializer #(.DIGEST_BITS(224), .OUT_WIDTH(64)) u_d224 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(sample), .dout(if1), .ofree(ofree1), .overflow(ovf1));
  sha3_digest_serializer #(.DIGEST_BITS(512), .OUT_WIDTH(32)) u_d512 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(sample), .dout(if2), .ofree(ofree2), .overflow(ovf2));

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sbq [$];
  int          sel = 0;
  int          dbits_of [3] = '{256, 224, 512};
  int          ow_of    [3] = '{32, 64, 32};
  logic [63:0] lanes [8];
  int          n_asrt = 0;
  int          n_fail = 0;
  int          beats = 0;
  int          cyc_n = 0;
  int          first_beat = -1;
  int          last_beat = -1;
  logic        stalled = 1'b0;
  logic [63:0] st_data = '0;
  logic        st_last = 1'b0;
  logic [63:0] last_word = '0;

  logic [63:0] o_data;
  logic        o_valid, o_last, o_free, o_ovf;

  // Observe the configuration under test.
  always_comb begin
    o_data = '0; o_valid = 1'b0; o_last = 1'b0; o_free = 1'b0; o_ovf = 1'b0;
    case (sel)
      0: begin
        o_data = {32'h0, if0.odata}; o_valid = if0.ovalid; o_last = if0.olast;
        o_free = ofree0; o_ovf = ovf0;
      end
      1: begin
        o_data = if1.odata; o_valid = if1.ovalid; o_last = if1.olast;
        o_free = ofree1; o_ovf = ovf1;
      end
      default: begin
        o_data = {32'h0, if2.odata}; o_valid = if2.ovalid; o_last = if2.olast;
        o_free = ofree2; o_ovf = ovf2;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes();
    for (int c = 0; c < 5; c++) isa[c] = lanes[c];
    for (int c = 0; c < 3; c++) isb[c] = lanes[5+c];
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 8; i++) lanes[i] = {$urandom(), $urandom()};
  endtask

  // Expected words: digest bits little-endian by lane, bits past the digest forced to 0.
  function automatic void push_state(input int dbits, input int ow);
    logic [511:0] bits;
    exp_t         e;
    int           w;
    for (int i = 0; i < 8; i++) bits[i*64 +: 64] = lanes[i];
    for (int b = dbits; b < 512; b++) bits[b] = 1'b0;
    w = (dbits + ow - 1) / ow;
    for (int k = 0; k < w; k++) begin
      e.data = (ow == 32) ? {32'h0, bits[k*32 +: 32]} : bits[k*64 +: 64];
      e.last = (k == w - 1);
      sbq.push_back(e);
    end
  endfunction

  // One cycle, entered and left at the falling edge.
  task automatic cyc();
    exp_t e;
    if (stalled && rst_n) begin
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_data", o_data, st_data);
      chk("stall_last", 64'(o_last), 64'(st_last));
    end
    if (rst_n && o_valid && iready) begin
      beats++;
      if (first_beat < 0) first_beat = cyc_n;
      last_beat = cyc_n;
      n_asrt++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed data %h with no word expected", o_data);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("beat_data", o_data, e.data);
        chk("beat_last", 64'(o_last), 64'(e.last));
      end
      if (o_last) last_word = o_data;
    end
    stalled = rst_n && o_valid && !iready;
    st_data = o_data;
    st_last = o_last;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; sample = 1'b0; iready = 1'b0;
    cyc(); cyc();
    chk("rst_ovalid", 64'(o_valid), 64'd0);
    chk("rst_odata", o_data, 64'd0);
    chk("rst_olast", 64'(o_last), 64'd0);
    chk("rst_ofree", 64'(o_free), 64'd1);
    chk("rst_overflow", 64'(o_ovf), 64'd0);
    rst_n = 1'b1;
    sbq.delete();
    stalled = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < 5; c++) begin
      isa[c] = '0;
      isb[c] = {$urandom(), $urandom()};
      isc[c] = {$urandom(), $urandom()};
      isd[c] = {$urandom(), $urandom()};
      ise[c] = {$urandom(), $urandom()};
    end
    @(negedge clk);

    // Reset, then a single 256/32 digest with iready held high.
    sel = 0;
    reset_dut();
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 8; b++) lanes[i][8*b +: 8] = 8'(8*i + b);
    for (int i = 4; i < 8; i++) lanes[i] = 64'hC0FF_EE00_DEAD_0000 | 64'(i);
    drive_lanes();
    beats = 0; iready = 1'b1; sample = 1'b1;
    push_state(dbits_of[sel], ow_of[sel]);
    chk("t1_idle_before", 64'(o_valid), 64'd0);
    cyc();
    sample = 1'b0;
    chk("t1_latency_valid", 64'(o_valid), 64'd1);
    chk("t1_word0", o_data, 64'h0302_0100);
    repeat (12) cyc();
    chk("t1_beats", 64'(beats), 64'd8);
    chk("t1_drain", 64'(sbq.size()), 64'd0);
    chk("t1_last_word", last_word, 64'h1F1E_1D1C);
    chk("t1_idle_after", 64'(o_valid), 64'd0);

    // Same digest with iready stalling two of every three cycles.
    beats = 0; sample = 1'b1; iready = 1'b1;
    push_state(dbits_of[sel], ow_of[sel]);
    cyc();
    sample = 1'b0;
    for (int c = 0; c < 40; c++) begin
      iready = (c % 3 == 0);
      cyc();
    end
    chk("t2_beats", 64'(beats), 64'd8);
    chk("t2_drain", 64'(sbq.size()), 64'd0);

    // Three results spaced by the word count: contiguous beats, slot never used.
    beats = 0; first_beat = -1; iready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      rand_lanes();
      drive_lanes();
      sample = 1'b1;
      push_state(dbits_of[sel], ow_of[sel]);
      chk("t3_ofree", 64'(o_free), 64'd1);
      cyc();
      sample = 1'b0;
      repeat (7) begin
        chk("t3_ofree", 64'(o_free), 64'd1);
        cyc();
      end
    end
    repeat (10) cyc();
    chk("t3_beats", 64'(beats), 64'd24);
    chk("t3_contiguous", 64'(last_beat - first_beat), 64'd23);
    chk("t3_drain", 64'(sbq.size()), 64'd0);

    // Back-pressure with three consecutive results: third one is dropped.
    beats = 0; iready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      rand_lanes();
      drive_lanes();
      sample = 1'b1;
      if (p < 2) push_state(dbits_of[sel], ow_of[sel]);
      if (p == 1) chk("t4_ofree_before_hold", 64'(o_free), 64'd1);
      if (p == 2) begin
        chk("t4_ofree_held", 64'(o_free), 64'd0);
        chk("t4_overflow_early", 64'(o_ovf), 64'd0);
      end
      cyc();
    end
    sample = 1'b0;
    chk("t4_overflow", 64'(o_ovf), 64'd1);
    chk("t4_ofree", 64'(o_free), 64'd0);
    chk("t4_no_beats", 64'(beats), 64'd0);
    iready = 1'b1;
    repeat (25) cyc();
    chk("t4_beats", 64'(beats), 64'd16);
    chk("t4_drain", 64'(sbq.size()), 64'd0);
    chk("t4_overflow_sticky", 64'(o_ovf), 64'd1);
    chk("t4_ofree_after", 64'(o_free), 64'd1);

    // 224/64: last word carries only the low half of lane 3.
    sel = 1;
    reset_dut();
    beats = 0;
    for (int i = 0; i < 3; i++) lanes[i] = 64'hAAAA_AAAA_AAAA_AAA0 | 64'(i);
    lanes[3] = {32'h5A5A_1234, 32'hDEAD_BEEF};
    for (int i = 4; i < 8; i++) lanes[i] = {$urandom(), $urandom()};
    drive_lanes();
    iready = 1'b1; sample = 1'b1;
    push_state(dbits_of[sel], ow_of[sel]);
    cyc();
    sample = 1'b0;
    repeat (8) cyc();
    chk("t5_beats", 64'(beats), 64'd4);
    chk("t5_last_word", last_word, 64'h0000_0000_DEAD_BEEF);
    chk("t5_drain", 64'(sbq.size()), 64'd0);

    // 512/32: reset on the third beat with the holding slot full.
    sel = 2;
    reset_dut();
    beats = 0; iready = 1'b1;
    rand_lanes(); drive_lanes(); sample = 1'b1;
    push_state(dbits_of[sel], ow_of[sel]);
    cyc();
    rand_lanes(); drive_lanes();
    push_state(dbits_of[sel], ow_of[sel]);
    cyc();
    sample = 1'b0;
    chk("t6_ofree_full", 64'(o_free), 64'd0);
    cyc();
    chk("t6_beats_before", 64'(beats), 64'd2);
    rst_n = 1'b0;
    rand_lanes(); drive_lanes(); sample = 1'b1;
    cyc();
    rst_n = 1'b1; sample = 1'b0;
    sbq.delete();
    chk("t6_ovalid", 64'(o_valid), 64'd0);
    chk("t6_ofree", 64'(o_free), 64'd1);
    chk("t6_overflow", 64'(o_ovf), 64'd0);
    repeat (5) cyc();
    chk("t6_quiet", 64'(beats), 64'd2);
    rand_lanes(); drive_lanes(); sample = 1'b1;
    push_state(dbits_of[sel], ow_of[sel]);
    cyc();
    sample = 1'b0;
    repeat (20) cyc();
    chk("t6_beats_after", 64'(beats), 64'd18);
    chk("t6_drain", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
